// File: rtl/cache_def.sv
// Shared types and constants for the direct-mapped cache controller and its memory neighbour.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cache_def;

  localparam int NUM_SETS    = 1024;
  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 15;
  localparam int IDX_MSB = 14;
  localparam int IDX_LSB = 5;
  localparam int TAG_W   = TAG_MSB - TAG_LSB + 1;
  localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

  typedef logic [LINE_BITS-1:0] cache_data_type;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } cache_state_type;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// Bundles the CPU-side and memory-side buses of the cache controller.
// Ports: cpu_req/cpu_res (word requests and completion), mem_req/mem_data (line traffic).
// master = CPU + memory side (testbench), slave = cache controller.
interface dm_cache_ctrl_if;
  import cache_def::*;

  cpu_req_type    cpu_req;
  cpu_result_type cpu_res;
  mem_req_type    mem_req;
  mem_data_type   mem_data;

  modport master (
    output cpu_req,
    output mem_data,
    input  cpu_res,
    input  mem_req
  );

  modport slave (
    input  cpu_req,
    input  mem_data,
    output cpu_res,
    output mem_req
  );

endinterface

// File: rtl/dm_cache_store.sv
// Tag/valid/dirty and line storage for the direct-mapped cache; combinational read by index.
// Latency: read is combinational, writes land on the next rising clk edge.
// Backpressure: none; ports: idx, tag_we/tag_wdat, line_we/line_wdat, tag_rdat, line_rdat.
module dm_cache_store
  import cache_def::*;
#(
  parameter int SETS = NUM_SETS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(SETS)-1:0]  idx,
  input  logic                     tag_we,
  input  cache_tag_type            tag_wdat,
  input  logic                     line_we,
  input  cache_data_type           line_wdat,
  output cache_tag_type            tag_rdat,
  output cache_data_type           line_rdat
);

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  cache_data_type   line_mem [SETS];

  // Only the state bits are cleared; tags and data are don't-care while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (tag_we) begin
      valid_q[idx] <= tag_wdat.valid;
      dirty_q[idx] <= tag_wdat.dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we)  tag_mem[idx]  <= tag_wdat.tag;
    if (line_we) line_mem[idx] <= line_wdat;
  end

  assign tag_rdat  = '{valid: valid_q[idx], dirty: dirty_q[idx], tag: tag_mem[idx]};
  assign line_rdat = line_mem[idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller between CPU word requests and a line memory.
// Latency: hit 1 cycle, clean miss 3, dirty miss 4 (with an always-ready memory) after the capture edge.
// Backpressure: requests sampled only in IDLE; WRITE_BACK/ALLOCATE hold mem_req stable until mem_data.ready.
module dm_cache_ctrl
  import cache_def::*;
(
  input  logic             clk,
  input  logic             rst,
  dm_cache_ctrl_if.slave   bus
);

  cache_state_type state, next_state;
  cpu_req_type     req_q;

  cache_tag_type   tag_rdat, tag_wdat;
  cache_data_type  line_rdat, line_wdat;
  logic            tag_we, line_we;
  logic            hit;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       word;

  assign idx     = req_q.addr[IDX_MSB:IDX_LSB];
  assign req_tag = req_q.addr[TAG_MSB:TAG_LSB];
  assign word    = req_q.addr[4:2];

  // Byte offset and the captured valid bit are carried in req_q but never consulted.
  logic unused_req_bits;
  assign unused_req_bits = ^{req_q.addr[1:0], req_q.valid};

  dm_cache_store #(.SETS(NUM_SETS)) u_store (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .tag_we    (tag_we),
    .tag_wdat  (tag_wdat),
    .line_we   (line_we),
    .line_wdat (line_wdat),
    .tag_rdat  (tag_rdat),
    .line_rdat (line_rdat)
  );

  // Async reset of the state register is what drops mem_req.rw immediately on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.cpu_req.valid) req_q <= bus.cpu_req;
    end
  end

  always_comb begin
    next_state  = state;
    bus.cpu_res = '0;
    bus.mem_req = '0;
    tag_we      = 1'b0;
    tag_wdat    = '0;
    line_we     = 1'b0;
    line_wdat   = line_rdat;
    hit         = tag_rdat.valid && (tag_rdat.tag == req_tag);

    unique case (state)
      IDLE: begin
        if (bus.cpu_req.valid) next_state = COMPARE;
      end

      COMPARE: begin
        if (hit) begin
          bus.cpu_res.ready = 1'b1;
          if (req_q.rw) begin
            line_we                         = 1'b1;
            line_wdat[{word, 5'd0} +: 32]   = req_q.data;
            tag_we                          = 1'b1;
            tag_wdat                        = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
          end else begin
            bus.cpu_res.data = line_rdat[{word, 5'd0} +: 32];
          end
          next_state = IDLE;
        end else if (tag_rdat.valid && tag_rdat.dirty) begin
          next_state = WRITE_BACK;
        end else begin
          next_state = ALLOCATE;
        end
      end

      WRITE_BACK: begin
        // Victim address is rebuilt from the stored tag, not the request tag.
        bus.mem_req.addr  = {tag_rdat.tag, idx, 5'd0};
        bus.mem_req.data  = line_rdat;
        bus.mem_req.rw    = 1'b1;
        bus.mem_req.valid = 1'b1;
        if (bus.mem_data.ready) next_state = ALLOCATE;
      end

      ALLOCATE: begin
        bus.mem_req.addr  = {req_tag, idx, 5'd0};
        bus.mem_req.valid = 1'b1;
        if (bus.mem_data.ready) begin
          line_we    = 1'b1;
          line_wdat  = bus.mem_data.data;
          tag_we     = 1'b1;
          tag_wdat   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          // Re-enter COMPARE so a write miss merges its word into the fresh line.
          next_state = COMPARE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl with a small line-granular memory model.
// Latency: memory answers combinationally when enabled.
// Backpressure: mem_rdy_en can stall the memory to hold the controller in WRITE_BACK.
module tb_dm_cache_ctrl;
  import cache_def::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_cache_ctrl_if bus ();

  dm_cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- memory model: 64 lines, index {addr[15], addr[9:5]} ----------------
  cache_data_type mem [64];
  bit   mem_loaded = 1'b0;
  logic mem_rdy_en;

  function automatic logic [5:0] midx(input logic [31:0] a);
    return {a[15], a[9:5]};
  endfunction

  always_comb begin
    bus.mem_data = '0;
    if (bus.mem_req.valid) begin
      bus.mem_data.ready = mem_rdy_en;
      if (!bus.mem_req.rw) bus.mem_data.data = mem[midx(bus.mem_req.addr)];
    end
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      for (int w = 0; w < 8; w++) mem[34][w*32 +: 32] <= 32'hA000_0000 + 32'(w);
      mem_loaded <= 1'b1;
    end else if (bus.mem_req.valid && bus.mem_req.rw && bus.mem_data.ready) begin
      mem[midx(bus.mem_req.addr)] <= bus.mem_req.data;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    int          lat;
    bit          wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_w1;
    bit          alloc;
    logic [31:0] alloc_addr;
  } exp_t;

  exp_t sb [$];

  int n_chk  = 0;
  int n_fail = 0;

  bit          busy = 1'b0;
  int          lat_cnt;
  bit          wb_seen, alloc_seen;
  logic [31:0] wb_addr_seen, wb_w1_seen, alloc_addr_seen;

  task automatic chk(input string name, input logic [289:0] act, input logic [289:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge, pops on every cpu_res.ready.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          lat_cnt++;
          if (bus.mem_req.valid && bus.mem_req.rw) begin
            wb_seen      = 1'b1;
            wb_addr_seen = bus.mem_req.addr;
            wb_w1_seen   = bus.mem_req.data[63:32];
          end
          if (bus.mem_req.valid && !bus.mem_req.rw) begin
            alloc_seen      = 1'b1;
            alloc_addr_seen = bus.mem_req.addr;
          end
        end
        if (bus.cpu_res.ready) begin
          if (!busy || sb.size() == 0) begin
            chk("unexpected_ready", 290'(bus.cpu_res.ready), 290'(0));
          end else begin
            e = sb.pop_front();
            chk("rsp_data",  290'(bus.cpu_res.data), 290'(e.data));
            chk("rsp_lat",   290'(lat_cnt),          290'(e.lat));
            chk("wb_seen",   290'(wb_seen),          290'(e.wb));
            if (e.wb) begin
              chk("wb_addr", 290'(wb_addr_seen), 290'(e.wb_addr));
              chk("wb_w1",   290'(wb_w1_seen),   290'(e.wb_w1));
            end
            chk("alloc_seen", 290'(alloc_seen), 290'(e.alloc));
            if (e.alloc) chk("alloc_addr", 290'(alloc_addr_seen), 290'(e.alloc_addr));
            busy = 1'b0;
          end
        end
      end
    end
  end

  // Driver: pushes the expectation, raises valid, holds it until ready (bounded).
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rw,
                       input logic [31:0] exp_d, input int lat,
                       input bit wb, input logic [31:0] wba, input logic [31:0] wbw1,
                       input bit al, input logic [31:0] ala);
    exp_t e;
    bit   got;
    e = '{data: exp_d, lat: lat, wb: wb, wb_addr: wba, wb_w1: wbw1, alloc: al, alloc_addr: ala};
    sb.push_back(e);
    @(negedge clk);
    lat_cnt    = 0;
    wb_seen    = 1'b0;
    alloc_seen = 1'b0;
    busy       = 1'b1;
    bus.cpu_req = '{addr: a, data: d, rw: rw, valid: 1'b1};
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.cpu_res.ready) got = 1'b1;
    end
    if (!got) begin
      chk("ready_timeout", 290'(0), 290'(1));
      void'(sb.pop_back());
      busy = 1'b0;
    end
    bus.cpu_req = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    bus.cpu_req = '0;
    mem_rdy_en  = 1'b1;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cpu_res", 290'(bus.cpu_res), 290'(0));
    chk("rst_mem_req", 290'(bus.mem_req), 290'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mem_req", 290'(bus.mem_req), 290'(0));

    // Cold read: clean miss, memory line is zero.
    issue(32'h0000_0040, 32'h0, 1'b0, 32'h0, 3, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0040);
    // Write hit, then read it back.
    issue(32'h0000_0044, 32'hDEAD_BEEF, 1'b1, 32'h0, 1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    issue(32'h0000_0044, 32'h0, 1'b0, 32'hDEAD_BEEF, 1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    // Dirty eviction: same index 2, tag 1.
    issue(32'h0000_8044, 32'h0, 1'b0, 32'hA000_0001, 4, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF,
          1'b1, 32'h0000_8040);
    chk("mem_after_wb", 290'(mem[2][63:32]), 290'(32'hDEAD_BEEF));
    // Clean eviction: 0x8040 line is clean, the old line comes back from memory.
    issue(32'h0000_0044, 32'h0, 1'b0, 32'hDEAD_BEEF, 3, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0040);

    // Word select across one line at index 3.
    for (int i = 0; i < 8; i++) begin
      if (i == 0)
        issue(32'h0000_0060, 32'hC0DE_0000, 1'b1, 32'h0, 3, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0060);
      else
        issue(32'h0000_0060 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 1'b1, 32'h0, 1,
              1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    end
    for (int i = 0; i < 8; i++)
      issue(32'h0000_0060 + 32'(4*i), 32'h0, 1'b0, 32'hC0DE_0000 + 32'(i), 1,
            1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Reset during a stalled write-back.
    issue(32'h0000_0044, 32'h1234_5678, 1'b1, 32'h0, 1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    mem_rdy_en = 1'b0;
    @(negedge clk);
    bus.cpu_req = '{addr: 32'h0000_8044, data: 32'h0, rw: 1'b0, valid: 1'b1};
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_req.valid && bus.mem_req.rw) got = 1'b1;
    end
    chk("stall_wb_seen", 290'(got), 290'(1));
    chk("stall_wb_addr", 290'(bus.mem_req.addr), 290'(32'h0000_0040));
    rst = 1'b1;
    #1;
    chk("midrst_rw",    290'(bus.mem_req.rw),    290'(0));
    chk("midrst_valid", 290'(bus.mem_req.valid), 290'(0));
    chk("midrst_ready", 290'(bus.cpu_res.ready), 290'(0));
    bus.cpu_req = '0;
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    mem_rdy_en = 1'b1;
    chk("mem_unchanged", 290'(mem[2][63:32]), 290'(32'hDEAD_BEEF));
    // Line was invalidated, so this misses and refills from memory.
    issue(32'h0000_0044, 32'h0, 1'b0, 32'hDEAD_BEEF, 3, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0040);

    repeat (3) @(negedge clk);
    chk("sb_empty", 290'(sb.size()), 290'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule
